// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin nibble MUX scheduler.
package mux_sched_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  // Output stage states: EMPTY drives out_valid low, LOADED drives it high.
  typedef enum logic [0:0] {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } out_state_e;

  // Picks the next channel. With burst_ok and the last channel still full, the last
  // channel is kept. Otherwise scan last+1, +2, +3, +4; the fourth step wraps back to
  // last, so a lone full channel is always found.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_CH-1:0]  full,
                                               input logic [SEL_W-1:0] last,
                                               input logic             burst_ok);
    logic             found;
    logic [SEL_W-1:0] idx;
    rr_pick = last;
    found   = 1'b0;
    if (burst_ok && full[last]) begin
      found = 1'b1;
    end
    for (int k = 1; k <= N_CH; k++) begin
      idx = last + SEL_W'(k);
      if (!found && full[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_mux.sv
// Plain 4:1 word MUX; the scheduler uses it to pick one holding register.
module mux_rr_scheduler_mux #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] A3,
  input  logic [1:0]       M_select,
  output logic [WIDTH-1:0] M_out
);

  // Decode the select onto one of the four inputs.
  always_comb begin
    M_out = '0;
    unique case (M_select)
      2'd0: M_out = A0;
      2'd1: M_out = A1;
      2'd2: M_out = A2;
      2'd3: M_out = A3;
      default: M_out = '0;
    endcase
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Four-channel valid/ready front end for the nibble MUX. Each channel owns a one-word
// holding register; a round-robin pointer (with optional burst allowance) chooses which
// held word is pushed through the MUX into a registered valid/ready output stage.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned MAX_BURST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        ch_valid,
  output logic [3:0]        ch_ready,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic [DATA_W-1:0] ch2_data,
  input  logic [DATA_W-1:0] ch3_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_ch
);

  // Counter only needs to reach MAX_BURST-1.
  localparam int unsigned BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST - 1);

  logic [DATA_W-1:0]  ch_data [N_CH];
  logic [DATA_W-1:0]  hold_q  [N_CH];
  logic [N_CH-1:0]    full_q;
  logic [SEL_W-1:0]   last_q;
  logic [BURST_W-1:0] burst_cnt_q;
  out_state_e         state_q;
  logic [DATA_W-1:0]  out_data_q;
  logic [SEL_W-1:0]   out_ch_q;

  logic               slot_free;
  logic               grant;
  logic               burst_ok;
  logic               stay;
  logic [SEL_W-1:0]   sel;
  logic [DATA_W-1:0]  mux_out;

  // Gather the per-channel data ports into an indexable array.
  always_comb begin
    ch_data[0] = ch0_data;
    ch_data[1] = ch1_data;
    ch_data[2] = ch2_data;
    ch_data[3] = ch3_data;
  end

  // Grant decision: the output slot can take a word when empty or being drained.
  always_comb begin
    slot_free = (state_q == ST_EMPTY) || out_ready;
    grant     = slot_free && (|full_q);
    burst_ok  = (burst_cnt_q < BURST_LIM);
    stay      = burst_ok && full_q[last_q];
    sel       = rr_pick(full_q, last_q, burst_ok);
  end

  // Ready is pure registered state, so there is no combinational path from out_ready.
  assign ch_ready  = ~full_q;
  assign out_valid = (state_q == ST_LOADED);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

  mux_rr_scheduler_mux #(
    .WIDTH(DATA_W)
  ) u_mux (
    .A0      (hold_q[0]),
    .A1      (hold_q[1]),
    .A2      (hold_q[2]),
    .A3      (hold_q[3]),
    .M_select(sel),
    .M_out   (mux_out)
  );

  // Holding registers: a granted channel empties and cannot refill on the same edge,
  // because it was not ready going into that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (grant && (sel == SEL_W'(i))) begin
          full_q[i] <= 1'b0;
        end else if (ch_valid[i] && !full_q[i]) begin
          full_q[i] <= 1'b1;
          hold_q[i] <= ch_data[i];
        end
      end
    end
  end

  // Output FSM with registered data/channel, round-robin pointer and burst counter.
  // last_q resets to 3 so channel 0 is first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= SEL_W'(N_CH - 1);
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY, ST_LOADED: begin
          if (grant) begin
            state_q     <= ST_LOADED;
            out_data_q  <= mux_out;
            out_ch_q    <= sel;
            last_q      <= sel;
            burst_cnt_q <= stay ? (burst_cnt_q + BURST_W'(1)) : '0;
          end else if (slot_free) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler: a MAX_BURST=1 instance for the main scenarios and
// a MAX_BURST=2 instance for the burst scenario, both stepped from one initial block.
module tb_mux_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] ch_valid, ch_ready;
  logic [3:0] ch0_data, ch1_data, ch2_data, ch3_data;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic [1:0] out_ch;

  logic [3:0] ch_valid2, ch_ready2;
  logic [3:0] ch0_data2, ch1_data2, ch2_data2, ch3_data2;
  logic       out_valid2, out_ready2;
  logic [3:0] out_data2;
  logic [1:0] out_ch2;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp1 [6];
  logic [1:0] exp2 [6];

  mux_rr_scheduler #(.DATA_W(4), .MAX_BURST(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .ch0_data (ch0_data),
    .ch1_data (ch1_data),
    .ch2_data (ch2_data),
    .ch3_data (ch3_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ch   (out_ch)
  );

  mux_rr_scheduler #(.DATA_W(4), .MAX_BURST(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_valid (ch_valid2),
    .ch_ready (ch_ready2),
    .ch0_data (ch0_data2),
    .ch1_data (ch1_data2),
    .ch2_data (ch2_data2),
    .ch3_data (ch3_data2),
    .out_valid(out_valid2),
    .out_ready(out_ready2),
    .out_data (out_data2),
    .out_ch   (out_ch2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] d,
                           input logic [1:0] c, input logic [3:0] rdy);
    check({tag, ".valid"}, 8'(out_valid), 8'(v));
    check({tag, ".data"},  8'(out_data),  8'(d));
    check({tag, ".ch"},    8'(out_ch),    8'(c));
    check({tag, ".ready"}, 8'(ch_ready),  8'(rdy));
  endtask

  initial begin
    rst_n = 1'b0;
    ch_valid = '0; ch0_data = '0; ch1_data = '0; ch2_data = '0; ch3_data = '0;
    out_ready = 1'b0;
    ch_valid2 = '0; ch0_data2 = '0; ch1_data2 = '0; ch2_data2 = '0; ch3_data2 = '0;
    out_ready2 = 1'b0;
    exp1 = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
    exp2 = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 4'h0, 2'd0, 4'hF);
    rst_n = 1'b1;
    tick();
    check("release.ready", 8'(ch_ready), 8'hF);

    // Single word through channel 2
    ch_valid = 4'b0100; ch2_data = 4'hA; out_ready = 1'b1;
    tick();
    ch_valid = '0;
    check("single.accept", 8'(out_valid), 8'h0);
    check("single.ready2", 8'(ch_ready), 8'hB);
    tick();
    check_out("single.out", 1'b1, 4'hA, 2'd2, 4'hF);

    // Mid-stream reset with a word on the output and another held
    out_ready = 1'b0;
    ch_valid = 4'b0010; ch1_data = 4'h7;
    tick();
    ch_valid = '0;
    check_out("prereset", 1'b1, 4'hA, 2'd2, 4'hD);
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 4'h0, 2'd0, 4'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_out("post_reset", 1'b0, 4'h0, 2'd0, 4'hF);

    // Round robin over four full channels, with backpressure after the second grant
    ch_valid = 4'hF; ch0_data = 4'h1; ch1_data = 4'h2; ch2_data = 4'h3; ch3_data = 4'h4;
    tick();
    ch_valid = '0;
    check_out("rr.loaded", 1'b0, 4'h0, 2'd0, 4'h0);
    out_ready = 1'b1;
    tick();
    check_out("rr.g0", 1'b1, 4'h1, 2'd0, 4'h1);
    tick();
    check_out("rr.g1", 1'b1, 4'h2, 2'd1, 4'h3);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("bp.hold", 1'b1, 4'h2, 2'd1, 4'h3);
    end
    out_ready = 1'b1;
    tick();
    check_out("rr.g2", 1'b1, 4'h3, 2'd2, 4'h7);
    tick();
    check_out("rr.g3", 1'b1, 4'h4, 2'd3, 4'hF);
    tick();
    check("rr.drain", 8'(out_valid), 8'h0);

    // Wrap: last grant was ch3, only ch0 and ch3 full
    ch_valid = 4'b1001; ch0_data = 4'h5; ch3_data = 4'h6;
    tick();
    ch_valid = '0;
    check_out("wrap.loaded", 1'b0, 4'h4, 2'd3, 4'h6);
    tick();
    check_out("wrap.g0", 1'b1, 4'h5, 2'd0, 4'h7);
    tick();
    check_out("wrap.g3", 1'b1, 4'h6, 2'd3, 4'hF);
    tick();
    check("wrap.drain", 8'(out_valid), 8'h0);

    // Burst: ch1 and ch2 kept busy, output drained every other cycle so channels refill
    ch_valid = 4'b0110; ch1_data = 4'h1; ch2_data = 4'h2;
    ch_valid2 = 4'b0110; ch1_data2 = 4'h1; ch2_data2 = 4'h2;
    out_ready = 1'b0; out_ready2 = 1'b0;
    tick();
    tick();
    check("burst.first1", 8'(out_ch), 8'h1);
    check("burst.first2", 8'(out_ch2), 8'h1);
    for (int k = 0; k < 6; k++) begin
      out_ready = 1'b0; out_ready2 = 1'b0;
      tick();
      out_ready = 1'b1; out_ready2 = 1'b1;
      check("burst.valid2", 8'(out_valid2), 8'h1);
      check("burst.ch2",    8'(out_ch2),    8'(exp2[k]));
      check("burst.data2",  8'(out_data2),  8'(exp2[k]));
      check("rr1.ch",       8'(out_ch),     8'(exp1[k]));
      tick();
    end
    ch_valid = '0; ch_valid2 = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
